// File: rtl/uart_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_if
// Desc     : Native valid/ready register bus between an initiator and the UART.
// Revision : 1.0
// ============================================================================
interface uart_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              uart_valid;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_wstrb;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_ready;

  modport master (
    output uart_valid, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_responder
// Desc     : Register-bus UART, 8N1. Define UART_RXFIFO_EN for a 4-deep RX FIFO
//            instead of the single RX holding register.
// Revision : 1.0
// ============================================================================
module uart_bus_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic      clk,
  input  logic      reset,
  uart_bus_if.slave bus,
  output logic      txd,
  input  logic      rxd
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} uart_state_e;

  localparam logic [ADDR_W-1:0] REG_SOFTRESET = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_DIV       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_TXDATA    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_TXEN      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_RXEN      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_TXREADY   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] REG_RXREADY   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] REG_RXDATA    = ADDR_W'(7);

  logic              wr_en, rd_en, soft_rst, tx_start;
  logic [15:0]       div_q, div_d, div_eff;
  logic              txen_q, txen_d, rxen_q, rxen_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  uart_state_e       tx_state_q, tx_state_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              txd_q, txd_d;
  logic              rx_sync1_q, rx_sync2_q, rx_prev_q;
  uart_state_e       rx_state_q, rx_state_d;
  logic [15:0]       rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_push, rx_pop, push_ok, rx_empty, rx_full;
  logic [7:0]        rx_head;

  assign wr_en    = bus.uart_valid && (bus.uart_wstrb != 4'd0);
  assign rd_en    = bus.uart_valid && (bus.uart_wstrb == 4'd0);
  assign soft_rst = wr_en && (bus.uart_addr == REG_SOFTRESET) && bus.uart_wdata[0];
  assign div_eff  = (div_q < 16'd2) ? 16'd2 : div_q;
  assign tx_start = wr_en && (bus.uart_addr == REG_TXDATA) && txen_q && (tx_state_q == ST_IDLE);
  assign rx_pop   = rd_en && (bus.uart_addr == REG_RXDATA) && !rx_empty;
  // A pop in the same cycle frees the slot the completing byte needs.
  assign push_ok  = rx_push && (!rx_full || rx_pop) && !soft_rst;

  assign txd            = txd_q;
  assign bus.uart_ready = ready_q;
  assign bus.uart_rdata = rdata_q;

  always_comb begin
    div_d   = div_q;
    txen_d  = txen_q;
    rxen_d  = rxen_q;
    ready_d = bus.uart_valid;
    rdata_d = '0;
    if (wr_en) begin
      case (bus.uart_addr)
        REG_DIV: begin
          if (bus.uart_wstrb[0]) div_d[7:0]  = bus.uart_wdata[7:0];
          if (bus.uart_wstrb[1]) div_d[15:8] = bus.uart_wdata[15:8];
        end
        REG_TXEN: txen_d = bus.uart_wdata[0];
        REG_RXEN: rxen_d = bus.uart_wdata[0];
        default: ;
      endcase
    end
    if (rd_en) begin
      case (bus.uart_addr)
        REG_TXREADY: rdata_d[0]   = txen_q && (tx_state_q == ST_IDLE);
        REG_RXREADY: rdata_d[0]   = !rx_empty;
        REG_RXDATA:  rdata_d[7:0] = rx_empty ? 8'd0 : rx_head;
        default: ;
      endcase
    end
    if (soft_rst) begin
      txen_d = 1'b0;
      rxen_d = 1'b0;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d    = 1'b1;
        tx_cnt_d = 16'd0;
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_div_d   = div_eff;
          tx_shift_d = bus.uart_wdata[7:0];
          txd_d      = 1'b0;
        end
      end
      ST_START, ST_DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'd0;
          if (tx_state_q == ST_DATA && tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = (tx_state_q == ST_START) ? 3'd0 : tx_bit_q + 3'd1;
            tx_state_d = ST_DATA;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      default: begin
        if (tx_cnt_q == tx_div_q - 16'd1) tx_state_d = ST_IDLE;
      end
    endcase
    if (soft_rst) begin
      tx_state_d = ST_IDLE;
      txd_d      = 1'b1;
    end
  end

  // Sampling points are counted from the cycle the synchronized falling edge is seen.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rxen_q && rx_prev_q && !rx_sync2_q) begin
          rx_state_d = ST_START;
          rx_div_d   = div_eff;
        end
      end
      ST_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end
      end
      default: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_state_d = ST_IDLE;
          rx_push    = rx_sync2_q;
        end
      end
    endcase
    if (!rxen_q || soft_rst) rx_state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= 16'd0;
      txen_q     <= 1'b0;
      rxen_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd2;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd2;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      div_q      <= div_d;
      txen_q     <= txen_d;
      rxen_q     <= rxen_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

`ifdef UART_RXFIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  assign rx_empty = (count_q == 3'd0);
  assign rx_full  = (count_q == 3'd4);
  assign rx_head  = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b00, push_ok} - {2'b00, rx_pop};
    if (push_ok) begin
      fifo_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (rx_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (soft_rst) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q   <= '{default: 8'd0};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;

  assign rx_empty = !hold_vld_q;
  assign rx_full  = hold_vld_q;
  assign rx_head  = hold_q;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (rx_pop) hold_vld_d = 1'b0;
    if (push_ok) begin
      hold_d     = rx_shift_q;
      hold_vld_d = 1'b1;
    end
    if (soft_rst) hold_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif
endmodule
`default_nettype wire
